axi_llc_miss_router: RTL

- Routing stage between tag lookup and the hit/miss pipelines of the LLC.
- Takes each looked-up descriptor and buffers it in one entry.
- Sends it to the hit pipeline or the miss pipeline, using the tag result plus the per-ID/write ordering verdict returned by the miss counter block.
- Drives that block's count-up and count-down requests and keeps saturating performance counters.

---
 rtl/axi_llc_miss_router.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_llc_miss_router.sv
// LLC routing stage: buffers one looked-up descriptor and steers it to the hit or miss
// pipeline using the tag result and the miss-counter ordering verdict; keeps perf counters.
module axi_llc_miss_router #(
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned PayloadWidth = 64,
    parameter int unsigned PerfCntWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    desc_valid_i,
    output logic                    desc_ready_o,
    input  logic [IdWidth-1:0]      desc_id_i,
    input  logic                    desc_rw_i,
    input  logic                    desc_miss_i,
    input  logic [PayloadWidth-1:0] desc_payload_i,
    output logic                    hit_valid_o,
    input  logic                    hit_ready_i,
    output logic [IdWidth-1:0]      hit_id_o,
    output logic                    hit_rw_o,
    output logic [PayloadWidth-1:0] hit_payload_o,
    output logic                    miss_valid_o,
    input  logic                    miss_ready_i,
    output logic [IdWidth-1:0]      miss_id_o,
    output logic                    miss_rw_o,
    output logic [PayloadWidth-1:0] miss_payload_o,
    output logic [IdWidth-1:0]      cnt_up_id_o,
    output logic                    cnt_up_rw_o,
    output logic                    cnt_up_valid_o,
    input  logic                    to_miss_i,
    input  logic                    stall_i,
    input  logic                    done_valid_i,
    input  logic [IdWidth-1:0]      done_id_i,
    input  logic                    done_rw_i,
    output logic [IdWidth-1:0]      cnt_down_id_o,
    output logic                    cnt_down_rw_o,
    output logic                    cnt_down_valid_o,
    input  logic                    perf_clear_i,
    output logic [PerfCntWidth-1:0] perf_hit_o,
    output logic [PerfCntWidth-1:0] perf_miss_o,
    output logic [PerfCntWidth-1:0] perf_forced_o
);

    function automatic logic [PerfCntWidth-1:0] sat_inc(input logic [PerfCntWidth-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(PerfCntWidth-1){1'b0}}, 1'b1};
        end
    endfunction

    logic                    s_valid_q, s_valid_d;
    logic [IdWidth-1:0]      s_id_q, s_id_d;
    logic                    s_rw_q, s_rw_d;
    logic                    s_miss_q, s_miss_d;
    logic [PayloadWidth-1:0] s_payload_q, s_payload_d;

    logic                    hit_valid_q, hit_valid_d;
    logic [IdWidth-1:0]      hit_id_q, hit_id_d;
    logic                    hit_rw_q, hit_rw_d;
    logic [PayloadWidth-1:0] hit_payload_q, hit_payload_d;

    logic                    miss_valid_q, miss_valid_d;
    logic [IdWidth-1:0]      miss_id_q, miss_id_d;
    logic                    miss_rw_q, miss_rw_d;
    logic [PayloadWidth-1:0] miss_payload_q, miss_payload_d;

    logic                    down_valid_q, down_valid_d;
    logic [IdWidth-1:0]      down_id_q, down_id_d;
    logic                    down_rw_q, down_rw_d;

    logic [PerfCntWidth-1:0] perf_hit_q, perf_hit_d;
    logic [PerfCntWidth-1:0] perf_miss_q, perf_miss_d;
    logic [PerfCntWidth-1:0] perf_forced_q, perf_forced_d;

    logic route_miss_s, hit_free_s, miss_free_s;
    logic hit_fire_s, miss_fire_s, s_fire_s, load_s;

    // Routing decision and handshakes; the verdict for S arrives combinationally via to_miss_i.
    always_comb begin
        route_miss_s = s_miss_q | to_miss_i;
        hit_free_s   = ~hit_valid_q | hit_ready_i;
        miss_free_s  = ~miss_valid_q | miss_ready_i;
        hit_fire_s   = s_valid_q & ~route_miss_s & hit_free_s;
        miss_fire_s  = s_valid_q & route_miss_s & miss_free_s & ~stall_i;
        s_fire_s     = hit_fire_s | miss_fire_s;
        load_s       = desc_valid_i & (~s_valid_q | s_fire_s);
    end

    assign desc_ready_o   = ~s_valid_q | s_fire_s;
    assign cnt_up_id_o    = s_id_q;
    assign cnt_up_rw_o    = s_rw_q;
    assign cnt_up_valid_o = miss_fire_s;

    // Next state of the input entry and both output registers.
    always_comb begin
        s_valid_d      = s_valid_q;
        s_id_d         = s_id_q;
        s_rw_d         = s_rw_q;
        s_miss_d       = s_miss_q;
        s_payload_d    = s_payload_q;
        hit_valid_d    = hit_valid_q;
        hit_id_d       = hit_id_q;
        hit_rw_d       = hit_rw_q;
        hit_payload_d  = hit_payload_q;
        miss_valid_d   = miss_valid_q;
        miss_id_d      = miss_id_q;
        miss_rw_d      = miss_rw_q;
        miss_payload_d = miss_payload_q;

        if (load_s) begin
            s_valid_d   = 1'b1;
            s_id_d      = desc_id_i;
            s_rw_d      = desc_rw_i;
            s_miss_d    = desc_miss_i;
            s_payload_d = desc_payload_i;
        end else if (s_fire_s) begin
            s_valid_d = 1'b0;
        end else begin
            s_valid_d = s_valid_q;
        end

        if (hit_fire_s) begin
            hit_valid_d   = 1'b1;
            hit_id_d      = s_id_q;
            hit_rw_d      = s_rw_q;
            hit_payload_d = s_payload_q;
        end else if (hit_ready_i) begin
            hit_valid_d = 1'b0;
        end else begin
            hit_valid_d = hit_valid_q;
        end

        if (miss_fire_s) begin
            miss_valid_d   = 1'b1;
            miss_id_d      = s_id_q;
            miss_rw_d      = s_rw_q;
            miss_payload_d = s_payload_q;
        end else if (miss_ready_i) begin
            miss_valid_d = 1'b0;
        end else begin
            miss_valid_d = miss_valid_q;
        end
    end

    // Count-down is a straight one-cycle copy of done, so no beat can be lost.
    always_comb begin
        down_valid_d = done_valid_i;
        down_id_d    = done_id_i;
        down_rw_d    = done_rw_i;
    end

    // Saturating perf counters; clear wins over increment.
    always_comb begin
        perf_hit_d    = perf_hit_q;
        perf_miss_d   = perf_miss_q;
        perf_forced_d = perf_forced_q;
        if (perf_clear_i) begin
            perf_hit_d    = {PerfCntWidth{1'b0}};
            perf_miss_d   = {PerfCntWidth{1'b0}};
            perf_forced_d = {PerfCntWidth{1'b0}};
        end else begin
            if (hit_fire_s) begin
                perf_hit_d = sat_inc(perf_hit_q);
            end else begin
                perf_hit_d = perf_hit_q;
            end
            if (miss_fire_s & s_miss_q) begin
                perf_miss_d = sat_inc(perf_miss_q);
            end else begin
                perf_miss_d = perf_miss_q;
            end
            if (miss_fire_s & ~s_miss_q) begin
                perf_forced_d = sat_inc(perf_forced_q);
            end else begin
                perf_forced_d = perf_forced_q;
            end
        end
    end

    // State registers; reset discards any descriptor in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_valid_q      <= 1'b0;
            s_id_q         <= {IdWidth{1'b0}};
            s_rw_q         <= 1'b0;
            s_miss_q       <= 1'b0;
            s_payload_q    <= {PayloadWidth{1'b0}};
            hit_valid_q    <= 1'b0;
            hit_id_q       <= {IdWidth{1'b0}};
            hit_rw_q       <= 1'b0;
            hit_payload_q  <= {PayloadWidth{1'b0}};
            miss_valid_q   <= 1'b0;
            miss_id_q      <= {IdWidth{1'b0}};
            miss_rw_q      <= 1'b0;
            miss_payload_q <= {PayloadWidth{1'b0}};
            down_valid_q   <= 1'b0;
            down_id_q      <= {IdWidth{1'b0}};
            down_rw_q      <= 1'b0;
            perf_hit_q     <= {PerfCntWidth{1'b0}};
            perf_miss_q    <= {PerfCntWidth{1'b0}};
            perf_forced_q  <= {PerfCntWidth{1'b0}};
        end else begin
            s_valid_q      <= s_valid_d;
            s_id_q         <= s_id_d;
            s_rw_q         <= s_rw_d;
            s_miss_q       <= s_miss_d;
            s_payload_q    <= s_payload_d;
            hit_valid_q    <= hit_valid_d;
            hit_id_q       <= hit_id_d;
            hit_rw_q       <= hit_rw_d;
            hit_payload_q  <= hit_payload_d;
            miss_valid_q   <= miss_valid_d;
            miss_id_q      <= miss_id_d;
            miss_rw_q      <= miss_rw_d;
            miss_payload_q <= miss_payload_d;
            down_valid_q   <= down_valid_d;
            down_id_q      <= down_id_d;
            down_rw_q      <= down_rw_d;
            perf_hit_q     <= perf_hit_d;
            perf_miss_q    <= perf_miss_d;
            perf_forced_q  <= perf_forced_d;
        end
    end

    assign hit_valid_o      = hit_valid_q;
    assign hit_id_o         = hit_id_q;
    assign hit_rw_o         = hit_rw_q;
    assign hit_payload_o    = hit_payload_q;
    assign miss_valid_o     = miss_valid_q;
    assign miss_id_o        = miss_id_q;
    assign miss_rw_o        = miss_rw_q;
    assign miss_payload_o   = miss_payload_q;
    assign cnt_down_valid_o = down_valid_q;
    assign cnt_down_id_o    = down_id_q;
    assign cnt_down_rw_o    = down_rw_q;
    assign perf_hit_o       = perf_hit_q;
    assign perf_miss_o      = perf_miss_q;
    assign perf_forced_o    = perf_forced_q;

endmodule
